// File: rtl/flit_serializer.sv
// flit_serializer: takes one parallel packet (head, up to MAX_BODY_FLITS
// bodies, tail) and streams it out one flit per transfer over valid/ready.
module flit_serializer #(
    parameter int unsigned FLIT_WIDTH       = 16,
    parameter int unsigned MAX_BODY_FLITS   = 4,
    parameter int unsigned BODY_COUNT_WIDTH = $clog2(MAX_BODY_FLITS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_pkt_valid,
    output logic                        o_pkt_ready,
    input  logic [FLIT_WIDTH-1:0]       i_head_flit,
    input  logic [FLIT_WIDTH-1:0]       i_body_flit_1,
    input  logic [FLIT_WIDTH-1:0]       i_body_flit_2,
    input  logic [FLIT_WIDTH-1:0]       i_body_flit_3,
    input  logic [FLIT_WIDTH-1:0]       i_body_flit_4,
    input  logic [BODY_COUNT_WIDTH-1:0] i_body_count,
    input  logic [FLIT_WIDTH-1:0]       i_tail_flit,
    output logic [FLIT_WIDTH-1:0]       o_flit,
    output logic                        o_flit_valid,
    input  logic                        i_flit_ready,
    output logic [1:0]                  o_flit_type,
    output logic                        o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b10;
    localparam logic [1:0] TYPE_TAIL = 2'b11;
    localparam logic [BODY_COUNT_WIDTH-1:0] COUNT_MAX = BODY_COUNT_WIDTH'(MAX_BODY_FLITS);

    state_t                      r_state;
    logic [BODY_COUNT_WIDTH-1:0] r_idx;
    logic [BODY_COUNT_WIDTH-1:0] r_count;
    logic [FLIT_WIDTH-1:0]       r_body_1;
    logic [FLIT_WIDTH-1:0]       r_body_2;
    logic [FLIT_WIDTH-1:0]       r_body_3;
    logic [FLIT_WIDTH-1:0]       r_body_4;
    logic [FLIT_WIDTH-1:0]       r_tail;

    state_t                      w_state_nxt;
    logic [BODY_COUNT_WIDTH-1:0] w_idx_nxt;
    logic [FLIT_WIDTH-1:0]       w_flit_nxt;
    logic                        w_valid_nxt;
    logic [1:0]                  w_type_nxt;
    logic                        w_done_nxt;
    logic                        w_pkt_accept;
    logic                        w_xfer;
    logic [BODY_COUNT_WIDTH-1:0] w_idx_inc;
    logic [BODY_COUNT_WIDTH-1:0] w_count_clamped;
    logic [FLIT_WIDTH-1:0]       w_body_next;

    assign o_pkt_ready     = (r_state == IDLE);
    assign w_pkt_accept    = i_pkt_valid && (r_state == IDLE);
    assign w_xfer          = o_flit_valid && i_flit_ready;
    assign w_idx_inc       = r_idx + BODY_COUNT_WIDTH'(1);
    assign w_count_clamped = (i_body_count > COUNT_MAX) ? COUNT_MAX : i_body_count;

    // Body flit following the one currently presented at index r_idx.
    always_comb begin
        w_body_next = r_body_4;
        if (r_idx == BODY_COUNT_WIDTH'(0)) begin
            w_body_next = r_body_2;
        end else if (r_idx == BODY_COUNT_WIDTH'(1)) begin
            w_body_next = r_body_3;
        end
    end

    // Capture the packet payload on accept; held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_body_1 <= '0;
            r_body_2 <= '0;
            r_body_3 <= '0;
            r_body_4 <= '0;
            r_tail   <= '0;
        end else if (w_pkt_accept) begin
            r_count  <= w_count_clamped;
            r_body_1 <= i_body_flit_1;
            r_body_2 <= i_body_flit_2;
            r_body_3 <= i_body_flit_3;
            r_body_4 <= i_body_flit_4;
            r_tail   <= i_tail_flit;
        end
    end

    // Next state and next registered flit-side outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_flit_nxt  = o_flit;
        w_valid_nxt = o_flit_valid;
        w_type_nxt  = o_flit_type;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_flit_nxt  = '0;
                w_valid_nxt = 1'b0;
                w_type_nxt  = TYPE_NONE;
                if (w_pkt_accept) begin
                    w_state_nxt = HEAD;
                    w_idx_nxt   = '0;
                    w_flit_nxt  = i_head_flit;
                    w_valid_nxt = 1'b1;
                    w_type_nxt  = TYPE_HEAD;
                end
            end
            HEAD: begin
                if (w_xfer) begin
                    if (r_count == BODY_COUNT_WIDTH'(0)) begin
                        w_state_nxt = TAIL;
                        w_flit_nxt  = r_tail;
                        w_type_nxt  = TYPE_TAIL;
                    end else begin
                        w_state_nxt = BODY;
                        w_idx_nxt   = '0;
                        w_flit_nxt  = r_body_1;
                        w_type_nxt  = TYPE_BODY;
                    end
                end
            end
            BODY: begin
                if (w_xfer) begin
                    if (w_idx_inc == r_count) begin
                        w_state_nxt = TAIL;
                        w_flit_nxt  = r_tail;
                        w_type_nxt  = TYPE_TAIL;
                    end else begin
                        w_idx_nxt   = w_idx_inc;
                        w_flit_nxt  = w_body_next;
                    end
                end
            end
            TAIL: begin
                if (w_xfer) begin
                    w_state_nxt = IDLE;
                    w_flit_nxt  = '0;
                    w_valid_nxt = 1'b0;
                    w_type_nxt  = TYPE_NONE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            o_flit       <= '0;
            o_flit_valid <= 1'b0;
            o_flit_type  <= TYPE_NONE;
            o_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            o_flit       <= w_flit_nxt;
            o_flit_valid <= w_valid_nxt;
            o_flit_type  <= w_type_nxt;
            o_done       <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_flit_serializer.sv
// Bench for flit_serializer: expected {type, flit} pairs are queued when a
// packet is driven and popped as the serializer transfers flits.
module tb_flit_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_pkt_valid = 1'b0;
    logic        o_pkt_ready;
    logic [15:0] i_head_flit = '0;
    logic [15:0] i_body_flit_1 = '0;
    logic [15:0] i_body_flit_2 = '0;
    logic [15:0] i_body_flit_3 = '0;
    logic [15:0] i_body_flit_4 = '0;
    logic [2:0]  i_body_count = '0;
    logic [15:0] i_tail_flit = '0;
    logic [15:0] o_flit;
    logic        o_flit_valid;
    logic        i_flit_ready = 1'b0;
    logic [1:0]  o_flit_type;
    logic        o_done;

    int total = 0;
    int bad   = 0;
    logic [17:0] exp_q[$];

    flit_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .i_pkt_valid   (i_pkt_valid),
        .o_pkt_ready   (o_pkt_ready),
        .i_head_flit   (i_head_flit),
        .i_body_flit_1 (i_body_flit_1),
        .i_body_flit_2 (i_body_flit_2),
        .i_body_flit_3 (i_body_flit_3),
        .i_body_flit_4 (i_body_flit_4),
        .i_body_count  (i_body_count),
        .i_tail_flit   (i_tail_flit),
        .o_flit        (o_flit),
        .o_flit_valid  (o_flit_valid),
        .i_flit_ready  (i_flit_ready),
        .o_flit_type   (o_flit_type),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a packet and queue the flits it should produce.
    task automatic load_packet(input logic [15:0] h, input logic [15:0] b1,
                               input logic [15:0] b2, input logic [15:0] b3,
                               input logic [15:0] b4, input logic [2:0] cnt,
                               input logic [15:0] t);
        logic [15:0] b[4];
        int n;
        b[0] = b1; b[1] = b2; b[2] = b3; b[3] = b4;
        n = (int'(cnt) > 4) ? 4 : int'(cnt);
        i_pkt_valid   = 1'b1;
        i_head_flit   = h;
        i_body_flit_1 = b1;
        i_body_flit_2 = b2;
        i_body_flit_3 = b3;
        i_body_flit_4 = b4;
        i_body_count  = cnt;
        i_tail_flit   = t;
        exp_q.push_back({2'b01, h});
        for (int i = 0; i < n; i++) exp_q.push_back({2'b10, b[i]});
        exp_q.push_back({2'b11, t});
    endtask

    // Change packet inputs after accept; the DUT must ignore them.
    task automatic scramble();
        i_head_flit   = 16'($urandom);
        i_body_flit_1 = 16'($urandom);
        i_body_flit_2 = 16'($urandom);
        i_body_flit_3 = 16'($urandom);
        i_body_flit_4 = 16'($urandom);
        i_body_count  = 3'($urandom);
        i_tail_flit   = 16'($urandom);
    endtask

    function automatic logic [17:0] pop_exp();
        if (exp_q.size() == 0) return 18'h3FFFF;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        total++;
        if (o_flit !== 16'h0 || o_flit_valid !== 1'b0 || o_flit_type !== 2'b00 ||
            o_done !== 1'b0 || o_pkt_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_vals got flit=%h v=%b t=%b d=%b rdy=%b exp 0000 0 00 0 1",
                     o_flit, o_flit_valid, o_flit_type, o_done, o_pkt_ready);
        end
    endtask

    task automatic test_basic();
        logic [17:0] e;
        total++;
        if (o_pkt_ready !== 1'b1) begin
            bad++; $display("FAIL basic_ready_pre got %b exp 1", o_pkt_ready);
        end
        load_packet(16'hA000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 3'd4, 16'hC00F);
        i_flit_ready = 1'b1;
        step();
        i_pkt_valid = 1'b0;
        scramble();
        for (int k = 1; k <= 8; k++) begin
            if (k <= 6) begin
                e = pop_exp();
                total++;
                if (o_flit_valid !== 1'b1 || o_flit !== e[15:0] || o_flit_type !== e[17:16]) begin
                    bad++;
                    $display("FAIL basic_flit k=%0d got v=%b flit=%h type=%b exp v=1 flit=%h type=%b",
                             k, o_flit_valid, o_flit, o_flit_type, e[15:0], e[17:16]);
                end
                total++;
                if (o_pkt_ready !== 1'b0) begin
                    bad++; $display("FAIL basic_busy k=%0d got rdy=%b exp 0", k, o_pkt_ready);
                end
            end
            total++;
            if (o_done !== (k == 7)) begin
                bad++; $display("FAIL basic_done k=%0d got %b exp %b", k, o_done, (k == 7));
            end
            if (k == 7) begin
                total++;
                if (o_flit_valid !== 1'b0 || o_flit !== 16'h0 || o_flit_type !== 2'b00 ||
                    o_pkt_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL basic_idle got v=%b flit=%h t=%b rdy=%b exp 0 0000 00 1",
                             o_flit_valid, o_flit, o_flit_type, o_pkt_ready);
                end
            end
            step();
        end
    endtask

    task automatic test_zero_body();
        logic [17:0] e;
        int nflits = 0;
        load_packet(16'h1111, 16'hEEE1, 16'hEEE2, 16'hEEE3, 16'hEEE4, 3'd0, 16'h2222);
        i_flit_ready = 1'b1;
        step();
        i_pkt_valid = 1'b0;
        scramble();
        for (int k = 1; k <= 5; k++) begin
            if (o_flit_valid === 1'b1) begin
                nflits++;
                e = pop_exp();
                total++;
                if (o_flit !== e[15:0] || o_flit_type !== e[17:16]) begin
                    bad++;
                    $display("FAIL zero_flit k=%0d got flit=%h type=%b exp flit=%h type=%b",
                             k, o_flit, o_flit_type, e[15:0], e[17:16]);
                end
            end
            total++;
            if (o_done !== (k == 3)) begin
                bad++; $display("FAIL zero_done k=%0d got %b exp %b", k, o_done, (k == 3));
            end
            step();
        end
        total++;
        if (nflits != 2) begin
            bad++; $display("FAIL zero_count got %0d flits exp 2", nflits);
        end
    endtask

    task automatic test_stall();
        logic [17:0] e;
        int ndone = 0;
        load_packet(16'h0AA0, 16'h0BB1, 16'h0BB2, 16'h0BB3, 16'h0BB4, 3'd2, 16'h0CCF);
        step();
        i_pkt_valid = 1'b0;
        scramble();
        for (int k = 1; k <= 10; k++) begin
            i_flit_ready = !(k >= 2 && k <= 4);
            if (k >= 2 && k <= 4) begin
                total++;
                if (o_flit !== 16'h0BB1 || o_flit_valid !== 1'b1 || o_flit_type !== 2'b10) begin
                    bad++;
                    $display("FAIL stall_hold k=%0d got flit=%h v=%b t=%b exp 0bb1 1 10",
                             k, o_flit, o_flit_valid, o_flit_type);
                end
            end
            if (o_flit_valid === 1'b1 && i_flit_ready) begin
                e = pop_exp();
                total++;
                if (o_flit !== e[15:0] || o_flit_type !== e[17:16]) begin
                    bad++;
                    $display("FAIL stall_flit k=%0d got flit=%h type=%b exp flit=%h type=%b",
                             k, o_flit, o_flit_type, e[15:0], e[17:16]);
                end
            end
            if (o_done === 1'b1) ndone++;
            total++;
            if (o_done !== (k == 8)) begin
                bad++; $display("FAIL stall_done k=%0d got %b exp %b", k, o_done, (k == 8));
            end
            step();
        end
        i_flit_ready = 1'b1;
        total++;
        if (ndone != 1) begin
            bad++; $display("FAIL stall_done_count got %0d exp 1", ndone);
        end
    endtask

    task automatic test_clamp();
        logic [17:0] e;
        int nflits = 0;
        load_packet(16'h3000, 16'h3001, 16'h3002, 16'h3003, 16'h3004, 3'd7, 16'h300F);
        i_flit_ready = 1'b1;
        step();
        i_pkt_valid = 1'b0;
        scramble();
        for (int k = 1; k <= 9; k++) begin
            if (o_flit_valid === 1'b1) begin
                nflits++;
                e = pop_exp();
                total++;
                if (o_flit !== e[15:0] || o_flit_type !== e[17:16]) begin
                    bad++;
                    $display("FAIL clamp_flit k=%0d got flit=%h type=%b exp flit=%h type=%b",
                             k, o_flit, o_flit_type, e[15:0], e[17:16]);
                end
            end
            total++;
            if (o_done !== (k == 7)) begin
                bad++; $display("FAIL clamp_done k=%0d got %b exp %b", k, o_done, (k == 7));
            end
            step();
        end
        total++;
        if (nflits != 6) begin
            bad++; $display("FAIL clamp_count got %0d flits exp 6", nflits);
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] e;
        load_packet(16'h5000, 16'h5001, 16'h5002, 16'h5003, 16'h5004, 3'd4, 16'h500F);
        i_flit_ready = 1'b1;
        step();
        i_pkt_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            e = pop_exp();
            total++;
            if (o_flit_valid !== 1'b1 || o_flit !== e[15:0] || o_flit_type !== e[17:16]) begin
                bad++;
                $display("FAIL rstmid_flit k=%0d got v=%b flit=%h type=%b exp v=1 flit=%h type=%b",
                         k, o_flit_valid, o_flit, o_flit_type, e[15:0], e[17:16]);
            end
            if (k < 3) step();
        end
        rst = 1'b1;
        #1;
        total++;
        if (o_flit_valid !== 1'b0 || o_flit !== 16'h0 || o_flit_type !== 2'b00 ||
            o_pkt_ready !== 1'b1 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async got v=%b flit=%h t=%b rdy=%b d=%b exp 0 0000 00 1 0",
                     o_flit_valid, o_flit, o_flit_type, o_pkt_ready, o_done);
        end
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (o_done !== 1'b0 || o_flit_valid !== 1'b0) begin
                bad++; $display("FAIL rstmid_quiet got d=%b v=%b exp 0 0", o_done, o_flit_valid);
            end
            step();
        end
        load_packet(16'h6000, 16'h6001, 16'h6002, 16'h6003, 16'h6004, 3'd1, 16'h600F);
        step();
        i_pkt_valid = 1'b0;
        scramble();
        for (int k = 1; k <= 5; k++) begin
            if (k <= 3) begin
                e = pop_exp();
                total++;
                if (o_flit_valid !== 1'b1 || o_flit !== e[15:0] || o_flit_type !== e[17:16]) begin
                    bad++;
                    $display("FAIL rstmid_next k=%0d got v=%b flit=%h type=%b exp v=1 flit=%h type=%b",
                             k, o_flit_valid, o_flit, o_flit_type, e[15:0], e[17:16]);
                end
            end
            total++;
            if (o_done !== (k == 4)) begin
                bad++; $display("FAIL rstmid_done k=%0d got %b exp %b", k, o_done, (k == 4));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        load_packet(16'h7000, 16'h7001, 16'h7002, 16'h7003, 16'h7004, 3'd1, 16'h700F);
        i_flit_ready = 1'b1;
        step();
        load_packet(16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h8004, 3'd1, 16'h800F);
        for (int k = 1; k <= 9; k++) begin
            if (k == 5) i_pkt_valid = 1'b0;
            if (o_flit_valid === 1'b1) begin
                e = pop_exp();
                total++;
                if (o_flit !== e[15:0] || o_flit_type !== e[17:16]) begin
                    bad++;
                    $display("FAIL b2b_flit k=%0d got flit=%h type=%b exp flit=%h type=%b",
                             k, o_flit, o_flit_type, e[15:0], e[17:16]);
                end
            end
            total++;
            if (o_flit_valid !== !(k == 4 || k >= 8)) begin
                bad++; $display("FAIL b2b_valid k=%0d got %b exp %b", k, o_flit_valid, !(k == 4 || k >= 8));
            end
            total++;
            if (o_done !== (k == 4 || k == 8)) begin
                bad++; $display("FAIL b2b_done k=%0d got %b exp %b", k, o_done, (k == 4 || k == 8));
            end
            total++;
            if (o_pkt_ready !== (k == 4 || k >= 8)) begin
                bad++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, o_pkt_ready, (k == 4 || k >= 8));
            end
            step();
        end
    endtask

    initial begin
        step();
        test_reset();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_basic();
        test_zero_body();
        test_stall();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL leftover_flits got %0d queued exp 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flit_serializer.md
Name: flit_serializer

Overview:
- Transmit-side counterpart to the NoC flit extractor.
- Accepts one complete packet in parallel: head flit, up to MAX_BODY_FLITS body flits and a tail flit.
- Emits the packet as a serial flit stream, head first, then bodies in order, then tail, using a valid/ready handshake toward the link.
- Sits between the packet-building logic and the router/link input that feeds the receiving extractor.

Parameters:
FLIT_WIDTH, 16, width of one flit in bits
MAX_BODY_FLITS, 4, maximum number of body flits per packet
BODY_COUNT_WIDTH, $clog2(MAX_BODY_FLITS+1), width of the body-count input (3 at default)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  reset; asynchronous, active-high
i_pkt_valid  input  1  packet-side valid; the parallel packet inputs are valid
o_pkt_ready  output  1  serializer can accept a packet
i_head_flit  input  FLIT_WIDTH  head flit
i_body_flit_1  input  FLIT_WIDTH  body flit 1
i_body_flit_2  input  FLIT_WIDTH  body flit 2
i_body_flit_3  input  FLIT_WIDTH  body flit 3
i_body_flit_4  input  FLIT_WIDTH  body flit 4
i_body_count  input  BODY_COUNT_WIDTH  number of body flits to send, 0..MAX_BODY_FLITS
i_tail_flit  input  FLIT_WIDTH  tail flit
o_flit  output  FLIT_WIDTH  serial flit out
o_flit_valid  output  1  o_flit holds a valid flit
i_flit_ready  input  1  downstream accepts the flit this cycle
o_flit_type  output  2  type of the flit on o_flit: 00 none, 01 head, 10 body, 11 tail
o_done  output  1  one-cycle pulse after the tail flit is transferred

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock.
  - State returns to IDLE.
  - Body index clears to 0.
  - Reset values: o_flit=0, o_flit_valid=0, o_flit_type=00, o_done=0, o_pkt_ready=1 (o_pkt_ready is decoded as state==IDLE).
  - Packet-side transfers are ignored while rst is high.
- FSM states: IDLE, HEAD, BODY, TAIL.
- Packet accept: occurs when i_pkt_valid && o_pkt_ready, in IDLE only, in cycle N.
  - Register all flit inputs and the body count.
  - i_body_count > MAX_BODY_FLITS is clamped to MAX_BODY_FLITS.
  - Go to HEAD.
  - At cycle N+1: o_flit=head, o_flit_valid=1, o_flit_type=01, o_pkt_ready=0.
- Flit transfer: occurs in any cycle with o_flit_valid && i_flit_ready.
  - While i_flit_ready is low, o_flit, o_flit_type and o_flit_valid hold stable.
  - o_flit_valid is never withdrawn before a transfer.
- HEAD transfer:
  - If the body count is 0, go to TAIL.
  - Otherwise go to BODY with idx=0; the next flit is body_1, type 10.
- BODY transfer: if idx+1 == count, go to TAIL; else idx increments and the next flit is body[idx+1].
  - Bodies are always sent in order 1..count.
  - Registered body flits beyond count are never emitted.
- TAIL: o_flit=tail, o_flit_type=11. On transfer:
  - Go to IDLE.
  - Next cycle: o_flit_valid=0, o_flit=0, o_flit_type=00, o_done=1 for exactly one cycle, o_pkt_ready=1.
- No overlap:
  - A new packet can be accepted no earlier than the cycle o_done is high.
  - Throughput with downstream always ready is count+2 flits per count+3 cycles.
- Outputs: all flit-side outputs are registered; no combinational path from i_flit_ready to o_flit or o_flit_valid.
- Registered packet data is stable from accept until return to IDLE; input changes after accept have no effect.
- Reset mid-packet: the packet is aborted, o_done is not pulsed, and outputs return to reset values immediately.
- i_pkt_valid high while not in IDLE: ignored; o_pkt_ready stays 0.

Test Plan:
1. Reset, then packet head=16'hA000, bodies 16'hB001..16'hB004, count=4, tail=16'hC00F, with ready always 1 -> flits A000,B001,B002,B003,B004,C00F on consecutive cycles N+1..N+6; types 01,10,10,10,10,11; o_done=1 at N+7 only; o_pkt_ready=1 at N+7.
2. count=0, head=16'h1111, tail=16'h2222 -> exactly two flits, 1111 (01) then 2222 (11); o_done two cycles after the head is first valid.
3. count=2, i_flit_ready low for 3 cycles while body_1=16'h0BB1 is presented -> o_flit holds 0BB1 with valid=1 for all stalled cycles; sequence completes unchanged; o_done fires once.
4. i_body_count=7 with MAX_BODY_FLITS=4 -> clamped: 4 bodies sent, 6 flits total.
5. Assert rst while body_2 is presented -> o_flit_valid=0, o_flit=0, o_flit_type=00, o_pkt_ready=1 immediately; no o_done; the next packet after reset is serialized correctly from its head.
6. Hold i_pkt_valid high continuously with new data, count=1 -> second packet is accepted in the o_done cycle; its head appears on the next cycle; the first packet is not corrupted.
